// File: rtl/ksa.sv
// ARC4 key-scheduling stage: walks i=0..255 over the shared single-port S memory,
// accumulating j and swapping S[i]/S[j]. All memory-facing outputs are registered.
module ksa #(
  parameter int KEY_LEN = 3,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 rdy,
  input  logic [8*KEY_LEN-1:0] key,
  output logic [7:0]           addr,
  input  logic [7:0]           rddata,
  output logic [7:0]           wrdata,
  output logic                 wren
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [2:0] {IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J} state_t;

  state_t                    state, state_n;
  logic [7:0]                i, i_n, j, j_n, si, si_n, sj, sj_n;
  logic [0:KEY_LEN-1][7:0]   key_q;
  logic [KW-1:0]             kidx, kidx_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [7:0]                addr_n, wrdata_n;
  logic                      wren_n;
  logic                      wait_done;

  // key_q is stored ascending so byte 0 (the MSB byte of key) sits at index 0
  assign wait_done = (cnt == CW'(RD_LAT - 1));

  always_comb begin
    state_n  = state;
    i_n      = i;
    j_n      = j;
    si_n     = si;
    sj_n     = sj;
    kidx_n   = kidx;
    cnt_n    = cnt;
    addr_n   = 8'd0;
    wrdata_n = wrdata;
    wren_n   = 1'b0;
    case (state)
      IDLE: if (en) begin
        i_n     = 8'd0;
        j_n     = 8'd0;
        kidx_n  = '0;
        state_n = RD_I;
      end
      RD_I: begin
        cnt_n   = '0;
        state_n = WT_I;
      end
      WT_I: if (wait_done) begin
        si_n    = rddata;
        j_n     = j + rddata + key_q[kidx];
        state_n = RD_J;
      end else cnt_n = cnt + 1'b1;
      RD_J: begin
        cnt_n   = '0;
        state_n = WT_J;
      end
      WT_J: if (wait_done) begin
        sj_n    = rddata;
        state_n = WR_I;
      end else cnt_n = cnt + 1'b1;
      WR_I: state_n = WR_J;
      WR_J: if (i == 8'hFF) state_n = IDLE;
      else begin
        i_n     = i + 8'd1;
        kidx_n  = (kidx == KW'(KEY_LEN - 1)) ? '0 : kidx + 1'b1;
        state_n = RD_I;
      end
      default: state_n = IDLE;
    endcase

    // Moore outputs are derived from the next state so they line up with it after the edge
    case (state_n)
      RD_I, WT_I: addr_n = i_n;
      RD_J, WT_J: addr_n = j_n;
      WR_I: begin
        addr_n   = i_n;
        wrdata_n = sj_n;
        wren_n   = 1'b1;
      end
      WR_J: begin
        addr_n   = j_n;
        wrdata_n = si_n;
        wren_n   = 1'b1;
      end
      default: addr_n = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      wren   <= 1'b0;
      addr   <= 8'd0;
      wrdata <= 8'd0;
      i      <= 8'd0;
      j      <= 8'd0;
      si     <= 8'd0;
      sj     <= 8'd0;
      key_q  <= '0;
      kidx   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      rdy    <= (state_n == IDLE);
      wren   <= wren_n;
      addr   <= addr_n;
      wrdata <= wrdata_n;
      i      <= i_n;
      j      <= j_n;
      si     <= si_n;
      sj     <= sj_n;
      kidx   <= kidx_n;
      cnt    <= cnt_n;
      if (state == IDLE && en) key_q <= key;
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: S memory with registered address, init preload, and an
// array-based ARC4 key-schedule reference model.
module tb_ksa;
  logic        clk = 1'b0;
  logic        rst_n, en, rdy, wren;
  logic [23:0] key_in;
  logic [7:0]  addr, rddata, wrdata;

  int checks = 0;
  int errors = 0;

  ksa #(.KEY_LEN(3), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key_in),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
  );

  always #5 clk = ~clk;

  // S memory: address registered, q combinational from the registered address
  logic [7:0] mem [256];
  logic [7:0] ram_a;
  logic       do_init;
  always @(posedge clk) begin
    if (do_init) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    else if (wren) mem[addr] <= wrdata;
    ram_a <= addr;
  end
  assign rddata = mem[ram_a];

  // write monitor: every second write of an iteration targets j
  int         wr_cnt;
  logic [7:0] jq[$];
  always @(negedge clk) if (wren) begin
    wr_cnt = wr_cnt + 1;
    if (wr_cnt % 2 == 0) jq.push_back(addr);
  end

  logic [7:0] ref_s [256];
  logic [7:0] ref_j [256];
  logic [7:0] s3    [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [23:0] k);
    int jj = 0;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(ref_s[x]) + int'((k >> (8 * (2 - x % 3))) & 24'hFF)) % 256;
      ref_j[x] = 8'(jj);
      t = ref_s[x]; ref_s[x] = ref_s[jj]; ref_s[jj] = t;
    end
  endtask

  task automatic init_s();
    @(negedge clk); do_init = 1'b1;
    @(negedge clk); do_init = 1'b0;
  endtask

  // returns edges from acceptance until rdy=1, or -1 if aborted by reset
  task automatic run(input logic [23:0] k, input int pulse_at, input int rst_at, output int cyc);
    wr_cnt = 0;
    jq.delete();
    @(negedge clk); key_in = k; en = 1'b1;
    @(posedge clk); #1; en = 1'b0; key_in = $urandom;
    cyc = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk); #1;
      en = (c == pulse_at);
      if (c == pulse_at) key_in = $urandom;
      if (c == rst_at) begin
        rst_n = 1'b0; #1;
        chk("midrst_rdy", rdy, 1);
        chk("midrst_wren", wren, 0);
        chk("midrst_addr", addr, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc = -1;
        return;
      end
      if (rdy) begin cyc = c; break; end
    end
    if (cyc == 0) chk("run_timeout", 0, 1);
  endtask

  task automatic cmp_mem(input string tag, input logic use_s3);
    int bad = 0;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== (use_s3 ? s3[k] : ref_s[k])) bad++;
    chk(tag, bad, 0);
  endtask

  int cyc;
  initial begin
    rst_n = 1'b0; en = 1'b0; key_in = '0; do_init = 1'b0;
    #23;
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", wren, 0);
    chk("rst_addr", addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // key 00033C: j trace, timing, write count, permutation
    init_s();
    run(24'h00033C, 0, 0, cyc);
    model(24'h00033C);
    chk("s2_cycles", cyc, 1536);
    chk("s2_writes", wr_cnt, 512);
    chk("s2_jcount", jq.size(), 256);
    if (jq.size() >= 3) begin
      chk("s2_j0", jq[0], 8'h00);
      chk("s2_j1", jq[1], 8'h04);
      chk("s2_j2", jq[2], 8'h42);
      begin
        int bad = 0;
        for (int k = 0; k < jq.size(); k++) if (jq[k] !== ref_j[k]) bad++;
        chk("s2_jtrace", bad, 0);
      end
    end
    cmp_mem("s2_final", 1'b0);
    begin
      bit seen [256];
      int dup = 0;
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      for (int k = 0; k < 256; k++) begin
        if (seen[mem[k]]) dup++;
        seen[mem[k]] = 1'b1;
      end
      chk("s2_perm", dup, 0);
    end
    for (int k = 0; k < 256; k++) s3[k] = mem[k];

    // zero key: i==j iterations and j=3 at i=2
    init_s();
    run(24'h000000, 0, 0, cyc);
    model(24'h000000);
    if (jq.size() >= 3) begin
      chk("s4_j0", jq[0], 8'h00);
      chk("s4_j1", jq[1], 8'h01);
      chk("s4_j2", jq[2], 8'h03);
    end else chk("s4_jcount", jq.size(), 256);
    cmp_mem("s4_final", 1'b0);

    // en pulse with new key mid-run is ignored
    init_s();
    run(24'h00033C, 100, 0, cyc);
    chk("s5_cycles", cyc, 1536);
    cmp_mem("s5_final", 1'b1);

    // reset at edge 700, re-init, rerun
    init_s();
    run(24'h00033C, 0, 700, cyc);
    chk("s6_abort", cyc, 32'hFFFFFFFF);
    init_s();
    run(24'h00033C, 0, 0, cyc);
    chk("s6_cycles", cyc, 1536);
    cmp_mem("s6_final", 1'b1);

    // random keys
    for (int r = 0; r < 4; r++) begin
      logic [23:0] k;
      k = 24'($urandom);
      init_s();
      run(k, 0, 0, cyc);
      model(k);
      chk("rnd_cycles", cyc, 1536);
      chk("rnd_writes", wr_cnt, 512);
      cmp_mem("rnd_final", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
